// File: rtl/dmem_stall_responder.sv
// -----------------------------------------------------------------------------
// dmem_stall_responder
//
// Data-memory responder for the M stage of the pipelined datapath. A load or
// store presented in M is captured, held for LATENCY wait cycles, then applied
// to an internal word array. While the access is outstanding memstallM is
// raised so the hazard unit freezes F/D/E/M and bubbles W. Load data is
// returned on the registered readdataM output.
//
// Request/stall handshake: the M stage keeps its request (memreadM/memwriteM
// plus address/data) asserted until it sees memstallM low. memstallM low
// while a request is present marks the single DONE cycle. In that cycle the
// access is complete, readdataM is valid for loads, and the pipeline advances
// on the closing edge. A request is sampled only in IDLE, so the request still
// present in DONE is never taken twice.
//
// Parameters
//   DEPTH    number of 32-bit words (power of two, 2..4096)
//   LATENCY  wait cycles spent in BUSY per access (1..15)
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous active-high reset (FSM, counter, read data)
//   memreadM    load request from M stage
//   memwriteM   store request from M stage (wins when both are high)
//   aluresultM  byte address, word index = aluresultM[AW+1:2]
//   writedataM  store data
//   readdataM   registered load data, unchanged by stores
//   memstallM   combinational stall request to the hazard unit
//   dbgState    current FSM state (0 IDLE, 1 BUSY, 2 DONE) for observation
// -----------------------------------------------------------------------------
module dmem_stall_responder #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memreadM,
   input  logic        memwriteM,
   input  logic [31:0] aluresultM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        memstallM,
   output logic [1:0]  dbgState
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state;
   state_t          stateNext;

   logic [3:0]      cnt;
   logic [AW-1:0]   idxQ;
   logic [31:0]     wdataQ;
   logic            weQ;
   logic [31:0]     rdata;

   logic [31:0]     mem [DEPTH];

   logic            req;
   logic            accept;
   logic            accessNow;
   logic            memWrite;
   logic            memRead;

   // Byte-offset bits and bits above the array size do not select a word.
   logic            unusedAddrBits;
   assign unusedAddrBits = ^{aluresultM[31:AW+2], aluresultM[1:0]};

   assign req = memreadM | memwriteM;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE: begin
            if (req) begin
               stateNext = BUSY;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               stateNext = DONE;
            end
         end
         DONE: begin
            // The request held in DONE belongs to the access just finished.
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Output / control decode
   // ---------------------------------------------------------------------------
   always_comb begin
      memstallM = req & (state != DONE);
      accept    = (state == IDLE) & req;
      accessNow = (state == BUSY) & (cnt == 4'd0);
      memWrite  = accessNow & weQ;
      memRead   = accessNow & ~weQ;
      dbgState  = state;
   end

   // ---------------------------------------------------------------------------
   // Request capture and wait counter
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= 4'd0;
         idxQ   <= '0;
         wdataQ <= 32'd0;
         weQ    <= 1'b0;
      end else begin
         if (accept) begin
            idxQ   <= aluresultM[AW+1:2];
            wdataQ <= writedataM;
            // A simultaneous read+write request is handled as a store.
            weQ    <= memwriteM;
            cnt    <= 4'(LATENCY - 1);
         end else if ((state == BUSY) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read-data register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= 32'd0;
      end else if (memRead) begin
         rdata <= mem[idxQ];
      end
   end

   assign readdataM = rdata;

   // ---------------------------------------------------------------------------
   // Word array. Not reset: a reset in BUSY forces the FSM to IDLE, which
   // removes the write strobe, so the pending store is dropped.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (memWrite) begin
         mem[idxQ] <= wdataQ;
      end
   end

endmodule

// File: tb/tb_dmem_stall_responder.sv
// -----------------------------------------------------------------------------
// Testbench for dmem_stall_responder (DEPTH=64, LATENCY=2).
// Driver tasks issue M-stage requests and push the readdataM value expected in
// each DONE cycle; a monitor pops and compares whenever a request is present
// and memstallM is low. Stall lengths and reset behaviour are checked by the
// driver directly.
// -----------------------------------------------------------------------------
module tb_dmem_stall_responder;

   localparam int DEPTH   = 64;
   localparam int LATENCY = 2;

   logic        clk;
   logic        reset;
   logic        memreadM;
   logic        memwriteM;
   logic [31:0] aluresultM;
   logic [31:0] writedataM;
   logic [31:0] readdataM;
   logic        memstallM;
   logic [1:0]  dbgState;

   logic [31:0] exp_q[$];
   int          checks;
   int          errors;

   dmem_stall_responder #(
      .DEPTH   (DEPTH),
      .LATENCY (LATENCY)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .memreadM   (memreadM),
      .memwriteM  (memwriteM),
      .aluresultM (aluresultM),
      .writedataM (writedataM),
      .readdataM  (readdataM),
      .memstallM  (memstallM),
      .dbgState   (dbgState)
   );

   // ---------------------------------------------------------------------------
   // Clock / reset
   // ---------------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Check helper
   // ---------------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks (called just after a rising edge)
   // ---------------------------------------------------------------------------
   // Present one request, hold it until the DONE cycle, then leave it after
   // the closing edge. expRd is readdataM expected in that DONE cycle.
   task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] expRd,
                            input string name);
      int highs;
      bit done;
      memreadM   = rd;
      memwriteM  = wr;
      aluresultM = addr;
      writedataM = data;
      exp_q.push_back(expRd);
      highs = 0;
      done  = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (memstallM) highs++;
         else done = 1'b1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s stall timeout: stall still high after 20 cycles", name);
      end else begin
         check({name, " stall cycles"}, 32'(highs), 32'(LATENCY + 1));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic go_idle(input int n);
      memreadM  = 1'b0;
      memwriteM = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // ---------------------------------------------------------------------------
   // Scoreboard monitor: DONE cycle = request present with stall low
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (!reset && (memreadM || memwriteM) && !memstallM) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done without expectation: readdataM=0x%08h, no entry queued", readdataM);
         end else begin
            check("done readdataM", readdataM, exp_q.pop_front());
         end
      end
      if (!(memreadM || memwriteM)) begin
         check("stall without req", 32'(memstallM), 32'd0);
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      checks     = 0;
      errors     = 0;
      reset      = 1'b1;
      memreadM   = 1'b0;
      memwriteM  = 1'b0;
      aluresultM = 32'd0;
      writedataM = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset readdataM", readdataM, 32'd0);
      check("reset state", 32'(dbgState), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Idle for 5 cycles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle readdataM", readdataM, 32'd0);
         check("idle stall", 32'(memstallM), 32'd0);
      end
      @(posedge clk);
      #1;

      // Store then load
      do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, "store 0x10");
      go_idle(1);
      do_access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "load 0x10");
      go_idle(1);
      do_access(1'b0, 1'b1, 32'h14, 32'h12345678, 32'hDEADBEEF, "store 0x14");
      go_idle(1);

      // Back-to-back loads held in M: stall 1,1,1,0,1,1,1,0
      do_access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, "b2b load 0x10");
      do_access(1'b1, 1'b0, 32'h14, 32'h0, 32'h12345678, "b2b load 0x14");
      go_idle(1);

      // Address aliasing and ignored low bits
      do_access(1'b0, 1'b1, 32'h100, 32'hA5A5A5A5, 32'h12345678, "store 0x100");
      do_access(1'b1, 1'b0, 32'h000, 32'h0, 32'hA5A5A5A5, "load 0x000 wrap");
      do_access(1'b1, 1'b0, 32'h103, 32'h0, 32'hA5A5A5A5, "load 0x103 low bits");
      go_idle(1);

      // Reset during the second BUSY cycle drops the store
      do_access(1'b0, 1'b1, 32'h20, 32'h11111111, 32'hA5A5A5A5, "store 0x20");
      go_idle(1);
      memwriteM  = 1'b1;
      aluresultM = 32'h20;
      writedataM = 32'h22222222;
      @(posedge clk); #1;   // first BUSY cycle
      @(posedge clk); #1;   // second BUSY cycle
      check("second busy state", 32'(dbgState), 32'd1);
      reset     = 1'b1;
      memwriteM = 1'b0;
      @(negedge clk);
      check("reset mid stall", 32'(memstallM), 32'd0);
      check("reset mid readdataM", readdataM, 32'd0);
      check("reset mid state", 32'(dbgState), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      go_idle(1);
      do_access(1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111, "load 0x20 after reset");
      go_idle(1);

      // Both read and write high: behaves as a store
      do_access(1'b1, 1'b0, 32'h14, 32'h0, 32'h12345678, "load 0x14 again");
      go_idle(1);
      do_access(1'b1, 1'b1, 32'h30, 32'h0BADF00D, 32'h12345678, "rd+wr 0x30");
      go_idle(1);
      @(negedge clk);
      check("rd+wr keeps readdataM", readdataM, 32'h12345678);
      @(posedge clk); #1;
      do_access(1'b1, 1'b0, 32'h30, 32'h0, 32'h0BADF00D, "load 0x30");
      go_idle(2);

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "time limit");
   end

endmodule
